// File: rtl/pipeline_control_unit_if.sv
// Bundles the ID-stage decode inputs, the EX branch result and the per-stage
// control outputs of pipeline_control_unit into one port.
// The master side drives the ID stage and observes control. The slave side is the control unit itself.
interface pipeline_control_unit_if;
  // ID-stage instruction fields
  logic        id_valid;
  logic [4:0]  id_opcode;
  logic        id_funct7_0;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  // EX-stage branch comparator result
  logic        ex_branch_taken;
  // Per-stage control bundles and destination indices
  logic [10:0] ex_ctrl;
  logic [10:0] mem_ctrl;
  logic [10:0] wb_ctrl;
  logic [4:0]  ex_rd;
  logic [4:0]  mem_rd;
  logic [4:0]  wb_rd;
  logic        ex_muldiv;
  // Hazard controls for the front end
  logic        stall;
  logic        flush;

  modport master (
    output id_valid, id_opcode, id_funct7_0, id_rs1, id_rs2, id_rd, ex_branch_taken,
    input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, ex_muldiv, stall, flush
  );

  modport slave (
    input  id_valid, id_opcode, id_funct7_0, id_rs1, id_rs2, id_rd, ex_branch_taken,
    output ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, ex_muldiv, stall, flush
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// Registered control path for a 5-stage RISC-V pipeline.
// The ID opcode is decoded into an 11-bit control bundle. The bundle is then
// carried through the ID/EX, EX/MEM and MEM/WB stages.
// The block also raises load-use stalls and taken-branch/jump flushes, and it
// holds EX for several cycles while a multiply/divide executes.
// Bundle bit order: {isBranch, MemRead, MemtoReg, ALUOp[1:0], MemWrite,
//                    ALUSrc, RegWrite, jump, WBSrc[1:0]}
module pipeline_control_unit #(
  parameter int M_EXT      = 0,  // 1 enables mul/div decode and the EX hold
  parameter int MULDIV_LAT = 4   // EX occupancy of a mul/div, 1..15
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_control_unit_if.slave  bus
);

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OPCODE_LOAD    = 5'b00000;
  localparam logic [4:0] OPCODE_ARITH_I = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC   = 5'b00101;
  localparam logic [4:0] OPCODE_STORE   = 5'b01000;
  localparam logic [4:0] OPCODE_ARITH_R = 5'b01100;
  localparam logic [4:0] OPCODE_LUI     = 5'b01101;
  localparam logic [4:0] OPCODE_BRANCH  = 5'b11000;
  localparam logic [4:0] OPCODE_JALR    = 5'b11001;
  localparam logic [4:0] OPCODE_JAL     = 5'b11011;

  // Control bundles per instruction class
  localparam logic [10:0] CTRL_NONE    = 11'b00000000000;
  localparam logic [10:0] CTRL_ARITH_R = 11'b00010001000;
  localparam logic [10:0] CTRL_ARITH_I = 11'b00010011000;
  localparam logic [10:0] CTRL_LOAD    = 11'b01100011000;
  localparam logic [10:0] CTRL_STORE   = 11'b00000110000;
  localparam logic [10:0] CTRL_BRANCH  = 11'b10001000000;
  localparam logic [10:0] CTRL_JAL     = 11'b00000001111;
  localparam logic [10:0] CTRL_JALR    = 11'b00000011111;
  localparam logic [10:0] CTRL_AUIPC   = 11'b00000001010;
  localparam logic [10:0] CTRL_LUI     = 11'b00000001001;

  // Bundle field positions used by the hazard logic
  localparam int B_IS_BRANCH = 10;
  localparam int B_MEM_READ  = 9;
  localparam int B_JUMP      = 2;

  // Starting value of the hold counter when a mul/div enters EX
  localparam logic [3:0] MD_CNT_LOAD = 4'(MULDIV_LAT - 1);
  localparam logic       M_EXT_EN    = (M_EXT != 0);

  // Decoded ID-stage control
  logic [10:0] id_ctrl;
  logic        id_muldiv;

  // Hazard terms
  logic load_use;
  logic md_hold;
  logic flush;
  logic stall;

  // Stage registers
  logic [10:0] ex_ctrl_q,  ex_ctrl_d;
  logic [4:0]  ex_rd_q,    ex_rd_d;
  logic        ex_muldiv_q, ex_muldiv_d;
  logic [10:0] mem_ctrl_q, mem_ctrl_d;
  logic [4:0]  mem_rd_q,   mem_rd_d;
  logic [10:0] wb_ctrl_q,  wb_ctrl_d;
  logic [4:0]  wb_rd_q,    wb_rd_d;
  logic [3:0]  md_cnt_q,   md_cnt_d;

  // Decode the ID opcode into its control bundle; invalid slots decode to a bubble
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    id_ctrl = CTRL_NONE;
    if (bus.id_valid) begin
      case (bus.id_opcode)
        OPCODE_ARITH_R: id_ctrl = CTRL_ARITH_R;
        OPCODE_ARITH_I: id_ctrl = CTRL_ARITH_I;
        OPCODE_LOAD:    id_ctrl = CTRL_LOAD;
        OPCODE_STORE:   id_ctrl = CTRL_STORE;
        OPCODE_BRANCH:  id_ctrl = CTRL_BRANCH;
        OPCODE_JAL:     id_ctrl = CTRL_JAL;
        OPCODE_JALR:    id_ctrl = CTRL_JALR;
        OPCODE_AUIPC:   id_ctrl = CTRL_AUIPC;
        OPCODE_LUI:     id_ctrl = CTRL_LUI;
        default:        id_ctrl = CTRL_NONE;
      endcase
    end
    id_muldiv = M_EXT_EN & bus.id_valid & (bus.id_opcode == OPCODE_ARITH_R) & bus.id_funct7_0;
  end

  // Hazard detection: redirect from EX, load-use on ID sources, mul/div occupancy
  always_comb begin
    flush    = (ex_ctrl_q[B_IS_BRANCH] & bus.ex_branch_taken) | ex_ctrl_q[B_JUMP];
    load_use = ex_ctrl_q[B_MEM_READ] & (ex_rd_q != 5'd0) & bus.id_valid &
               ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2));
    md_hold  = ex_muldiv_q & (md_cnt_q != 4'd0);
    // A flush discards the instruction in ID, so there is nothing left to stall.
    stall    = ~flush & (load_use | md_hold);
  end

  // ID/EX next state: flush bubbles, mul/div holds, load-use bubbles, else advance
  always_comb begin
    ex_ctrl_d   = ex_ctrl_q;
    ex_rd_d     = ex_rd_q;
    ex_muldiv_d = ex_muldiv_q;
    if (flush || (!md_hold && load_use)) begin
      ex_ctrl_d   = CTRL_NONE;
      ex_rd_d     = 5'd0;
      ex_muldiv_d = 1'b0;
    end else if (!md_hold) begin
      ex_ctrl_d   = id_ctrl;
      ex_rd_d     = bus.id_rd;
      ex_muldiv_d = id_muldiv;
    end
  end

  // EX/MEM and MEM/WB next state: EX/MEM takes a bubble while EX is still busy
  always_comb begin
    if (md_hold) begin
      mem_ctrl_d = CTRL_NONE;
      mem_rd_d   = 5'd0;
    end else begin
      mem_ctrl_d = ex_ctrl_q;
      mem_rd_d   = ex_rd_q;
    end
    wb_ctrl_d = mem_ctrl_q;
    wb_rd_d   = mem_rd_q;
  end

  // Mul/div hold counter: loaded as a mul/div enters EX, counts down while holding
  always_comb begin
    md_cnt_d = 4'd0;
    if (md_hold) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end else if (!flush && !load_use && id_muldiv) begin
      md_cnt_d = MD_CNT_LOAD;
    end
  end

  // Stage registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      ex_ctrl_q   <= CTRL_NONE;
      ex_rd_q     <= 5'd0;
      ex_muldiv_q <= 1'b0;
      mem_ctrl_q  <= CTRL_NONE;
      mem_rd_q    <= 5'd0;
      wb_ctrl_q   <= CTRL_NONE;
      wb_rd_q     <= 5'd0;
      md_cnt_q    <= 4'd0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      ex_muldiv_q <= ex_muldiv_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_rd_q    <= mem_rd_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_rd_q     <= wb_rd_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

  assign bus.ex_ctrl   = ex_ctrl_q;
  assign bus.mem_ctrl  = mem_ctrl_q;
  assign bus.wb_ctrl   = wb_ctrl_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.ex_muldiv = ex_muldiv_q;
  assign bus.stall     = stall;
  assign bus.flush     = flush;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit.
// Two instances share one stimulus stream:
//   dut_m: M_EXT=1, MULDIV_LAT=4 (the main instance)
//   dut_n: M_EXT=0 (used for the single-cycle mul/div flow)
// Inputs change 1 ns after a rising edge, and outputs are checked 1 ns after that.
module tb_pipeline_control_unit;

  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_ARITH_I = 5'b00100;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_ARITH_R = 5'b01100;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_BOGUS   = 5'b11111;

  localparam logic [10:0] C_ARITH_R = 11'b00010001000;
  localparam logic [10:0] C_ARITH_I = 11'b00010011000;
  localparam logic [10:0] C_LOAD    = 11'b01100011000;
  localparam logic [10:0] C_STORE   = 11'b00000110000;
  localparam logic [10:0] C_BRANCH  = 11'b10001000000;
  localparam logic [10:0] C_JAL     = 11'b00000001111;
  localparam logic [10:0] C_JALR    = 11'b00000011111;
  localparam logic [10:0] C_AUIPC   = 11'b00000001010;
  localparam logic [10:0] C_LUI     = 11'b00000001001;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  pipeline_control_unit_if ifm ();
  pipeline_control_unit_if ifn ();

  pipeline_control_unit #(.M_EXT(1), .MULDIV_LAT(4)) dut_m (.clk(clk), .rst(rst), .bus(ifm));
  pipeline_control_unit #(.M_EXT(0), .MULDIV_LAT(4)) dut_n (.clk(clk), .rst(rst), .bus(ifn));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic taken);
    ifm.id_valid = v;  ifm.id_opcode = op; ifm.id_funct7_0 = f7;
    ifm.id_rs1 = rs1;  ifm.id_rs2 = rs2;   ifm.id_rd = rd;  ifm.ex_branch_taken = taken;
    ifn.id_valid = v;  ifn.id_opcode = op; ifn.id_funct7_0 = f7;
    ifn.id_rs1 = rs1;  ifn.id_rs2 = rs2;   ifn.id_rd = rd;  ifn.ex_branch_taken = taken;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode table for the remaining opcodes: each one flows alone into EX
  logic [4:0]  dec_op  [7];
  logic        dec_v   [7];
  logic [10:0] dec_exp [7];

  initial begin
    logic [10:0] e;
    passed = 0;
    total  = 0;
    dec_op[0] = OP_STORE;   dec_v[0] = 1'b1; dec_exp[0] = C_STORE;
    dec_op[1] = OP_JAL;     dec_v[1] = 1'b1; dec_exp[1] = C_JAL;
    dec_op[2] = OP_JALR;    dec_v[2] = 1'b1; dec_exp[2] = C_JALR;
    dec_op[3] = OP_AUIPC;   dec_v[3] = 1'b1; dec_exp[3] = C_AUIPC;
    dec_op[4] = OP_LUI;     dec_v[4] = 1'b1; dec_exp[4] = C_LUI;
    dec_op[5] = OP_BOGUS;   dec_v[5] = 1'b1; dec_exp[5] = 11'd0;
    dec_op[6] = OP_ARITH_R; dec_v[6] = 1'b0; dec_exp[6] = 11'd0;

    // Reset held for two cycles under random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
            5'($urandom), 5'($urandom), 1'($urandom));
      tick();
    end
    check("rst_ex_ctrl",   ifm.ex_ctrl,          11'd0);
    check("rst_mem_ctrl",  ifm.mem_ctrl,         11'd0);
    check("rst_wb_ctrl",   ifm.wb_ctrl,          11'd0);
    check("rst_ex_rd",     11'(ifm.ex_rd),       11'd0);
    check("rst_mem_rd",    11'(ifm.mem_rd),      11'd0);
    check("rst_wb_rd",     11'(ifm.wb_rd),       11'd0);
    check("rst_ex_muldiv", 11'(ifm.ex_muldiv),   11'd0);
    check("rst_stall",     11'(ifm.stall),       11'd0);
    check("rst_flush",     11'(ifm.flush),       11'd0);
    rst = 1'b0;
    idle();
    tick();

    // Load rd=5 followed by a dependent Arith_R: one bubble
    drive(1'b1, OP_LOAD, 1'b0, 5'd1, 5'd2, 5'd5, 1'b0);
    #1;
    check("lu_pre_stall", 11'(ifm.stall), 11'd0);
    tick();
    drive(1'b1, OP_ARITH_R, 1'b0, 5'd5, 5'd3, 5'd6, 1'b0);
    #1;
    check("lu_ex_load",  ifm.ex_ctrl,       C_LOAD);
    check("lu_ex_rd",    11'(ifm.ex_rd),    11'd5);
    check("lu_stall",    11'(ifm.stall),    11'd1);
    check("lu_flush",    11'(ifm.flush),    11'd0);
    tick();
    #1;
    check("lu_bubble",   ifm.ex_ctrl,       11'd0);
    check("lu_stall_1c", 11'(ifm.stall),    11'd0);
    check("lu_mem_load", ifm.mem_ctrl,      C_LOAD);
    tick();
    idle();
    #1;
    check("lu_ex_arith", ifm.ex_ctrl,       C_ARITH_R);
    check("lu_ex_rd6",   11'(ifm.ex_rd),    11'd6);
    check("lu_mem_bub",  ifm.mem_ctrl,      11'd0);
    check("lu_wb_load",  ifm.wb_ctrl,       C_LOAD);
    check("lu_wb_rd",    11'(ifm.wb_rd),    11'd5);
    tick();

    // Same pattern with rd=0: x0 never creates a hazard
    drive(1'b1, OP_LOAD, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(1'b1, OP_ARITH_R, 1'b0, 5'd0, 5'd3, 5'd6, 1'b0);
    #1;
    check("x0_stall",    11'(ifm.stall),    11'd0);
    tick();
    idle();
    #1;
    check("x0_ex_arith", ifm.ex_ctrl,       C_ARITH_R);
    tick();
    tick();

    // Taken branch while ID holds a Load that consumes an older load's result
    drive(1'b1, OP_LOAD, 1'b0, 5'd1, 5'd2, 5'd7, 1'b0);
    tick();
    drive(1'b1, OP_BRANCH, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(1'b1, OP_LOAD, 1'b0, 5'd7, 5'd2, 5'd8, 1'b1);
    #1;
    check("br_ex_branch", ifm.ex_ctrl,      C_BRANCH);
    check("br_flush",     11'(ifm.flush),   11'd1);
    check("br_stall",     11'(ifm.stall),   11'd0);
    tick();
    idle();
    #1;
    check("br_ex_bubble", ifm.ex_ctrl,      11'd0);
    check("br_mem_branch", ifm.mem_ctrl,    C_BRANCH);
    check("br_flush_off", 11'(ifm.flush),   11'd0);
    tick();

    // Branch not taken: no flush, following instruction advances
    drive(1'b1, OP_BRANCH, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(1'b1, OP_ARITH_I, 1'b0, 5'd3, 5'd0, 5'd4, 1'b0);
    #1;
    check("bnt_flush",    11'(ifm.flush),   11'd0);
    tick();
    idle();
    #1;
    check("bnt_ex_arith", ifm.ex_ctrl,      C_ARITH_I);
    tick();
    tick();

    // Remaining opcodes, invalid opcode and id_valid=0
    for (int i = 0; i < 7; i++) begin
      drive(dec_v[i], dec_op[i], 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
      tick();
      idle();
      #1;
      e = dec_exp[i];
      check($sformatf("dec_ex_ctrl_%0d", i), ifm.ex_ctrl,    e);
      check($sformatf("dec_flush_%0d", i),   11'(ifm.flush), 11'(e[2]));
      tick();
    end
    tick();

    // Mul/div: M_EXT=1 holds EX for 3 extra cycles, M_EXT=0 flows in one cycle
    drive(1'b1, OP_ARITH_R, 1'b1, 5'd1, 5'd2, 5'd9, 1'b0);
    #1;
    check("md_pre_stall", 11'(ifm.stall), 11'd0);
    tick();
    drive(1'b1, OP_ARITH_I, 1'b0, 5'd3, 5'd0, 5'd10, 1'b0);
    #1;
    check("md_t0_ex",      ifm.ex_ctrl,        C_ARITH_R);
    check("md_t0_muldiv",  11'(ifm.ex_muldiv), 11'd1);
    check("md_t0_stall",   11'(ifm.stall),     11'd1);
    check("nm_t0_muldiv",  11'(ifn.ex_muldiv), 11'd0);
    check("nm_t0_stall",   11'(ifn.stall),     11'd0);
    tick();
    #1;
    check("md_t1_stall",   11'(ifm.stall),     11'd1);
    check("md_t1_mem",     ifm.mem_ctrl,       11'd0);
    check("md_t1_ex",      ifm.ex_ctrl,        C_ARITH_R);
    check("nm_t1_mem",     ifn.mem_ctrl,       C_ARITH_R);
    check("nm_t1_mem_rd",  11'(ifn.mem_rd),    11'd9);
    check("nm_t1_ex",      ifn.ex_ctrl,        C_ARITH_I);
    tick();
    #1;
    check("md_t2_stall",   11'(ifm.stall),     11'd1);
    check("md_t2_mem",     ifm.mem_ctrl,       11'd0);
    tick();
    #1;
    check("md_t3_stall",   11'(ifm.stall),     11'd0);
    check("md_t3_mem",     ifm.mem_ctrl,       11'd0);
    check("md_t3_ex",      ifm.ex_ctrl,        C_ARITH_R);
    tick();
    idle();
    #1;
    check("md_t4_mem",     ifm.mem_ctrl,       C_ARITH_R);
    check("md_t4_mem_rd",  11'(ifm.mem_rd),    11'd9);
    check("md_t4_ex",      ifm.ex_ctrl,        C_ARITH_I);
    check("md_t4_ex_rd",   11'(ifm.ex_rd),     11'd10);
    tick();
    tick();
    tick();

    // Reset during the second cycle of a mul/div hold discards it
    drive(1'b1, OP_ARITH_R, 1'b1, 5'd1, 5'd2, 5'd11, 1'b0);
    tick();
    idle();
    tick();
    check("mr_stall_pre",  11'(ifm.stall),     11'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mr_ex_ctrl",    ifm.ex_ctrl,        11'd0);
    check("mr_ex_muldiv",  11'(ifm.ex_muldiv), 11'd0);
    check("mr_stall",      11'(ifm.stall),     11'd0);
    check("mr_mem_ctrl",   ifm.mem_ctrl,       11'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mr_mem_after_%0d", i), ifm.mem_ctrl, 11'd0);
      check($sformatf("mr_wb_after_%0d", i),  ifm.wb_ctrl,  11'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Registered control path for the 5-stage RISC-V pipeline. Decodes the ID-stage opcode into the 11-bit control bundle and carries it through the ID/EX, EX/MEM and MEM/WB stages. Generates load-use stalls, taken-branch/jump flushes, and an optional multi-cycle EX hold for M-extension multiply/divide. It replaces the purely combinational decoder: datapath stage registers keep only data, and this block alone owns control timing.

## Interface
- M_EXT, 0: 1 enables M-extension decode and the multi-cycle EX hold.
- MULDIV_LAT, 4: EX-stage occupancy of a mul/div instruction in cycles, legal range 1..15. Counter width is 4 bits.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  5  instr[6:2], matched against the `OPCODE_*` macros in defines.v.
- id_funct7_0  in  1  instr[25]. With `OPCODE_Arith_R` and M_EXT=1, marks mul/div.
- id_rs1, id_rs2, id_rd  in  5 each  ID register indices.
- ex_branch_taken  in  1  branch comparator result for the EX instruction.
- ex_ctrl, mem_ctrl, wb_ctrl  out  11 each  per-stage bundle {isBranch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite, jump, WBSrc[1:0]}.
- ex_rd, mem_rd, wb_rd  out  5 each  destination index per stage.
- ex_muldiv  out  1  EX instruction is mul/div.
- stall  out  1  hold PC and IF/ID this cycle.
- flush  out  1  squash IF/ID this cycle.

## Operation
- Decode (combinational, ID). Bundle values by opcode:
  - Arith_R 00010001000
  - Arith_I 00010011000
  - Load 01100011000
  - Store 00000110000
  - Branch 10001000000
  - JAL 00000001111
  - JALR 00000011111
  - AUIPC 00000001010
  - LUI 00000001001
  - any other opcode, or id_valid=0: all zeros.
- id_muldiv = M_EXT & id_valid & (opcode==Arith_R) & id_funct7_0.
- flush = (ex_ctrl.isBranch & ex_branch_taken) | ex_ctrl.jump.
- load_use = ex_ctrl.MemRead & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
- md_hold = ex_muldiv & (md_cnt!=0).
- stall = ~flush & (load_use | md_hold).
- ID/EX update, first matching rule wins:
  - flush: bubble (bundle 0, rd 0, muldiv 0).
  - md_hold: hold contents.
  - load_use: bubble.
  - otherwise: load the decoded bundle, id_rd and id_muldiv.
- EX/MEM update:
  - md_hold: bubble.
  - otherwise: copy of ID/EX.
- MEM/WB always copies EX/MEM. No stage enable exists beyond the rules above.
- md_cnt (4 bit):
  - Loaded with MULDIV_LAT-1 when a mul/div instruction enters ID/EX.
  - Decrements while md_hold is asserted.
  - 0 otherwise.
  - With MULDIV_LAT=1 a mul/div instruction behaves exactly like an ALU op.
- Reset: all bundles, rd fields, ex_muldiv and md_cnt are 0. stall and flush are 0 because they derive from zeroed registers.

## Timing
- Decode-to-ex_ctrl latency is 1 cycle. ex to mem and mem to wb are 1 cycle each.
- Load-use gives exactly one bubble. The dependent instruction reaches EX 2 cycles after the load did.
- Mul/div entering EX at cycle t:
  - stall is high for cycles t..t+MULDIV_LAT-2.
  - Result moves to mem_ctrl at t+MULDIV_LAT.
  - mem_ctrl is 0 for cycles t+1..t+MULDIV_LAT-1.
- A taken branch or jump in EX asserts flush in the same cycle. The next ex_ctrl is 0.
- Flush and load_use in the same cycle: flush wins and stall=0. A flush cannot coincide with md_hold, since EX holds one instruction.
- rst asserted mid-operation, including during md_hold: every register is 0 on the next edge. Any in-flight mul/div is discarded.

## Test plan
- Reset: hold rst for 2 cycles with random inputs -> all outputs 0, stall=0, flush=0.
- Load then use:
  - Stimulus: Load rd=5, then Arith_R rs1=5.
  - Required: stall=1 for 1 cycle, ex_ctrl=0 for 1 cycle, then ex_ctrl=00010001000.
  - Required: the same sequence with rd=0 gives no stall.
- Taken branch:
  - Stimulus: Branch with ex_branch_taken=1 while ID holds a Load that depends on an older load.
  - Required: flush=1, stall=0, next ex_ctrl=0.
- Mul/div, M_EXT=1, MULDIV_LAT=4:
  - Stimulus: Arith_R with funct7_0=1.
  - Required: stall high for 3 cycles, three zero mem_ctrl cycles, then mem_ctrl=00010001000.
- Mul/div with M_EXT=0: same stimulus -> no stall, single-cycle flow.
- Reset mid-operation: assert rst during the second cycle of a mul/div hold -> all registers 0 next cycle, stall=0, no mem_ctrl output for the instruction.
